team_07_spi_arbiter: RTL and testbench

//  Shares one SPI master port (sclk/cs_n/mosi; miso on GPIO[6]) between two requesters inside team_07.
//  - Round-robin grant; each grant is one full-duplex DW-bit transfer.
//  - Drives the transfer in SPI mode 0, MSB first, and returns the received word to the granted requester.
//  - New transfers start only while the design enable `en` is high.

---
 rtl/team_07_spi_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_team_07_spi_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_07_spi_arbiter.sv
// Two-requester round-robin arbiter for a single SPI mode-0 master port.
// Each grant runs one full-duplex, MSB-first DW-bit transfer.
module team_07_spi_arbiter #(
  parameter int DW      = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic [1:0]      req_valid,
  input  logic [2*DW-1:0] req_data,
  output logic [1:0]      req_ready,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            busy,
  output logic            sclk,
  output logic            cs_n,
  output logic            mosi,
  input  logic            miso
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DW) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [BW-1:0] bit_q,       bit_d;
  logic          sclk_q,      sclk_d;
  logic          cs_n_q,      cs_n_d;
  logic          mosi_q,      mosi_d;
  logic [DW-1:0] tx_q,        tx_d;
  logic [DW-1:0] rx_q,        rx_d;
  logic          last_q,      last_d;
  logic [1:0]    req_ready_q, req_ready_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q,  rsp_data_d;
  logic          busy_q,      busy_d;

  logic          cnt_last;
  logic          win;
  logic          accept;
  logic [DW-1:0] tx_sel;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign win      = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign tx_sel   = last_q ? req_data[DW +: DW] : req_data[0 +: DW];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    last_d      = last_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    accept      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_ready_q) begin
          // req_ready is visible this cycle, so the requester still drives its word.
          tx_d    = tx_sel;
          mosi_d  = tx_sel[DW-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          busy_d = 1'b0;
          accept = en && (|req_valid);
        end
      end

      ST_SETUP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SHIFT: begin
        if (sclk_q && (cnt_q == '0)) begin
          rx_d = {rx_q[DW-2:0], miso};
        end
        if (cnt_last) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != BIT_LAST) begin
              mosi_d = tx_q[DW-2];
              tx_d   = {tx_q[DW-2:0], 1'b0};
            end
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q + BW'(1);
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        if (cnt_last) begin
          cnt_d       = '0;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = last_q ? 2'b10 : 2'b01;
          rsp_data_d  = rx_q;
          state_d     = ST_IDLE;
          // Arbitrating on the completion edge lets the next grant share the cs_n-high cycle.
          accept      = en && (|req_valid);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    if (accept) begin
      req_ready_d = win ? 2'b10 : 2'b01;
      last_d      = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_q      <= 1'b1;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_team_07_spi_arbiter.sv
// Directed bench for team_07_spi_arbiter: DUT 0 uses CLK_DIV=4, DUT 1 uses CLK_DIV=1,
// each with a mode-0 SPI slave model that records the word it received.
module tb_team_07_spi_arbiter;
  localparam int DW = 8;

  typedef struct {
    string      name;
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] stx;
    logic [1:0] exp_g;
    logic [7:0] exp_tx;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            nrst;
  logic            en;
  logic [1:0]      req_valid [2];
  logic [2*DW-1:0] req_data  [2];
  logic [1:0]      req_ready [2];
  logic [1:0]      rsp_valid [2];
  logic [DW-1:0]   rsp_data  [2];
  logic            busy      [2];
  logic            sclk      [2];
  logic            cs_n      [2];
  logic            mosi      [2];
  logic            miso      [2];

  logic [DW-1:0] stx [2];
  logic [DW-1:0] srx [2];
  int            sbit [2];
  int            srise [2];
  logic          psclk [2];
  logic          pcs [2];
  int            cap_cnt [2] = '{0, 0};
  logic [DW-1:0] cap_word [2];
  int            cap_rises [2];
  logic [DW-1:0] cap_hist [2][8];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  team_07_spi_arbiter #(.DW(DW), .CLK_DIV(4)) dut0 (
    .clk(clk), .nrst(nrst), .en(en),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0]),
    .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  team_07_spi_arbiter #(.DW(DW), .CLK_DIV(1)) dut1 (
    .clk(clk), .nrst(nrst), .en(en),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1]),
    .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  // Mode-0 slave: samples mosi after sclk rises, presents the next miso bit after it falls.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!nrst) begin
        psclk[k] = 1'b0;
        pcs[k]   = 1'b1;
        miso[k]  = 1'b0;
        sbit[k]  = 0;
        srise[k] = 0;
      end else begin
        if (pcs[k] && !cs_n[k]) begin
          sbit[k]  = 0;
          srise[k] = 0;
          miso[k]  = stx[k][DW-1];
        end
        if (!cs_n[k] && sclk[k] && !psclk[k]) begin
          srx[k] = {srx[k][DW-2:0], mosi[k]};
          srise[k]++;
        end
        if (!cs_n[k] && !sclk[k] && psclk[k]) begin
          sbit[k]++;
          if (sbit[k] < DW) miso[k] = stx[k][DW-1-sbit[k]];
        end
        if (!pcs[k] && cs_n[k]) begin
          cap_word[k]  = srx[k];
          cap_rises[k] = srise[k];
          cap_hist[k][cap_cnt[k] % 8] = srx[k];
          cap_cnt[k]++;
        end
        psclk[k] = sclk[k];
        pcs[k]   = cs_n[k];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int k, input int limit, output int t0, output logic [1:0] g);
    g  = '0;
    t0 = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (req_ready[k] != 2'b00) begin
        g  = req_ready[k];
        t0 = cyc;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int k, input int limit, output int t1,
                          output logic [1:0] v, output logic [7:0] d);
    t1 = -1;
    v  = '0;
    d  = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rsp_valid[k] != 2'b00) begin
        t1 = cyc;
        v  = rsp_valid[k];
        d  = rsp_data[k];
        break;
      end
    end
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] valid, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] s, input logic [1:0] g,
                              input logic [7:0] t);
    vec_t v;
    v.name = name; v.valid = valid; v.d0 = d0; v.d1 = d1;
    v.stx = s; v.exp_g = g; v.exp_tx = t;
    return v;
  endfunction

  // One transfer on DUT 0 from idle: grant, latency, RX word, and what the slave saw.
  task automatic run_vec(input vec_t v);
    int t0, t1, c0;
    logic [1:0] g, rv;
    logic [7:0] rd;
    stx[0]       = v.stx;
    req_data[0]  = {v.d1, v.d0};
    req_valid[0] = v.valid;
    wait_ready(0, 20, t0, g);
    req_valid[0] = 2'b00;
    check({v.name, " grant"}, 32'(g), 32'(v.exp_g));
    check({v.name, " busy@T"}, 32'(busy[0]), 32'd0);
    c0 = cap_cnt[0];
    @(negedge clk);
    check({v.name, " busy@T+1"}, 32'(busy[0]), 32'd1);
    wait_rsp(0, 300, t1, rv, rd);
    check({v.name, " latency"}, (t1 < 0) ? 32'hFFFF_FFFF : 32'(t1 - t0), 32'd73);
    check({v.name, " rsp_valid"}, 32'(rv), 32'(v.exp_g));
    check({v.name, " rsp_data"}, 32'(rd), 32'(v.stx));
    @(negedge clk);
    @(negedge clk);
    check({v.name, " slave_count"}, 32'(cap_cnt[0] - c0), 32'd1);
    check({v.name, " slave_word"}, 32'(cap_word[0]), 32'(v.exp_tx));
    check({v.name, " sclk_rises"}, 32'(cap_rises[0]), 32'd8);
  endtask

  vec_t vecs [7];

  initial begin
    int t0, t1, c0, bad, nres, ngr;
    logic [1:0] g, rv;
    logic [7:0] rd;
    logic [1:0] gseq [8];
    int         gcyc [8];
    logic [1:0] rseq [8];
    int         rcyc [8];
    int         per  [2];

    // Expected grants assume last_grant=1 out of reset and follow the chain through the table.
    vecs[0] = mk("single_a5",  2'b01, 8'hA5, 8'h00, 8'h3C, 2'b01, 8'hA5);
    vecs[1] = mk("single_r1",  2'b10, 8'h00, 8'h5A, 8'hC3, 2'b10, 8'h5A);
    vecs[2] = mk("tie_to_r0",  2'b11, 8'h11, 8'h22, 8'h81, 2'b01, 8'h11);
    vecs[3] = mk("tie_to_r1",  2'b11, 8'h11, 8'h22, 8'h7E, 2'b10, 8'h22);
    vecs[4] = mk("tie_again0", 2'b11, 8'h33, 8'h44, 8'h00, 2'b01, 8'h33);
    vecs[5] = mk("repeat_r0",  2'b01, 8'hFF, 8'h00, 8'hFF, 2'b01, 8'hFF);
    vecs[6] = mk("tie_after0", 2'b11, 8'h0F, 8'hF0, 8'h96, 2'b10, 8'hF0);

    nrst = 1'b0;
    en   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b11;
      req_data[k]  = '0;
      stx[k]       = '0;
    end

    // Reset with both requests asserted
    repeat (3) @(negedge clk);
    check("rst sclk", 32'(sclk[0]), 32'd0);
    check("rst cs_n", 32'(cs_n[0]), 32'd1);
    check("rst mosi", 32'(mosi[0]), 32'd0);
    check("rst req_ready", 32'(req_ready[0]), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst rsp_data", 32'(rsp_data[0]), 32'd0);
    check("rst busy", 32'(busy[0]), 32'd0);
    check("rst dut1 cs_n", 32'(cs_n[1]), 32'd1);
    nrst = 1'b1;
    req_valid[0] = 2'b00;
    req_valid[1] = 2'b00;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Continuous contention: each requester drops out after its second grant
    req_data[0]  = {8'h22, 8'h11};
    req_valid[0] = 2'b11;
    stx[0] = 8'h5C;
    nres = 0; ngr = 0; per[0] = 0; per[1] = 0;
    for (int j = 0; j < 8; j++) begin gseq[j] = '0; rseq[j] = '0; gcyc[j] = 0; rcyc[j] = 0; end
    c0 = cap_cnt[0];
    for (int i = 0; i < 600; i++) begin
      if (nres >= 4) break;
      @(negedge clk);
      if (req_ready[0] != 2'b00 && ngr < 8) begin
        gseq[ngr] = req_ready[0];
        gcyc[ngr] = cyc;
        per[int'(req_ready[0][1])]++;
        if (per[int'(req_ready[0][1])] == 2) req_valid[0][int'(req_ready[0][1])] = 1'b0;
        ngr++;
      end
      if (rsp_valid[0] != 2'b00 && nres < 8) begin
        rseq[nres] = rsp_valid[0];
        rcyc[nres] = cyc;
        nres++;
      end
    end
    req_valid[0] = 2'b00;
    repeat (2) @(negedge clk);
    check("rr grant0", 32'(gseq[0]), 32'd1);
    check("rr grant1", 32'(gseq[1]), 32'd2);
    check("rr grant2", 32'(gseq[2]), 32'd1);
    check("rr grant3", 32'(gseq[3]), 32'd2);
    check("rr rsp0", 32'(rseq[0]), 32'd1);
    check("rr rsp1", 32'(rseq[1]), 32'd2);
    check("rr rsp2", 32'(rseq[2]), 32'd1);
    check("rr rsp3", 32'(rseq[3]), 32'd2);
    check("rr first latency", 32'(rcyc[0] - gcyc[0]), 32'd73);
    check("rr b2b accept", 32'(gcyc[1] - rcyc[0]), 32'd0);
    check("rr slave0", 32'(cap_hist[0][(c0 + 0) % 8]), 32'h11);
    check("rr slave1", 32'(cap_hist[0][(c0 + 1) % 8]), 32'h22);
    check("rr slave2", 32'(cap_hist[0][(c0 + 2) % 8]), 32'h11);
    check("rr slave3", 32'(cap_hist[0][(c0 + 3) % 8]), 32'h22);

    // Enable low blocks acceptance
    en = 1'b0;
    req_data[0]  = {8'h00, 8'h77};
    req_valid[0] = 2'b01;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[0] != 2'b00 || cs_n[0] != 1'b1) bad++;
    end
    check("en0 gating", 32'(bad), 32'd0);

    // Dropping enable mid-transfer does not abort
    en = 1'b1;
    stx[0] = 8'h6D;
    wait_ready(0, 20, t0, g);
    req_valid[0] = 2'b00;
    check("en_drop grant", 32'(g), 32'd1);
    while (cyc < t0 + 20) @(negedge clk);
    en = 1'b0;
    wait_rsp(0, 300, t1, rv, rd);
    check("en_drop latency", (t1 < 0) ? 32'hFFFF_FFFF : 32'(t1 - t0), 32'd73);
    check("en_drop rsp_valid", 32'(rv), 32'd1);
    check("en_drop rsp_data", 32'(rd), 32'h6D);
    req_valid[0] = 2'b10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0] != 2'b00) bad++;
    end
    check("en_drop no accept", 32'(bad), 32'd0);
    req_valid[0] = 2'b00;
    en = 1'b1;
    @(negedge clk);

    // Reset in the middle of SHIFT
    stx[0] = 8'hE7;
    req_data[0]  = {8'h00, 8'h99};
    req_valid[0] = 2'b01;
    wait_ready(0, 20, t0, g);
    req_valid[0] = 2'b00;
    check("midrst grant", 32'(g), 32'd1);
    while (cyc < t0 + 30) @(negedge clk);
    check("midrst pre cs_n", 32'(cs_n[0]), 32'd0);
    nrst = 1'b0;
    @(negedge clk);
    check("midrst cs_n", 32'(cs_n[0]), 32'd1);
    check("midrst sclk", 32'(sclk[0]), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid[0] != 2'b00 || req_ready[0] != 2'b00) bad++;
    end
    check("midrst no rsp", 32'(bad), 32'd0);
    // last_grant was 0 before the reset; a tie now must go to requester 0 again
    run_vec(mk("post_rst_tie", 2'b11, 8'h3A, 8'hC5, 8'h18, 2'b01, 8'h3A));
    run_vec(mk("post_rst_r1",  2'b10, 8'h00, 8'h5A, 8'hA3, 2'b10, 8'h5A));

    // CLK_DIV=1 instance
    stx[1] = 8'h00;
    req_data[1]  = {8'h00, 8'hFF};
    req_valid[1] = 2'b01;
    wait_ready(1, 20, t0, g);
    req_valid[1] = 2'b00;
    check("div1 grant", 32'(g), 32'd1);
    c0 = cap_cnt[1];
    bad = 0;
    t1 = -1; rv = '0; rd = 8'hXX;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 17 && sclk[1] !== ((k % 2) == 0)) bad++;
      if (rsp_valid[1] != 2'b00 && t1 < 0) begin
        t1 = cyc;
        rv = rsp_valid[1];
        rd = rsp_data[1];
      end
    end
    check("div1 sclk toggle", 32'(bad), 32'd0);
    check("div1 latency", (t1 < 0) ? 32'hFFFF_FFFF : 32'(t1 - t0), 32'd19);
    check("div1 rsp_valid", 32'(rv), 32'd1);
    check("div1 rsp_data", 32'(rd), 32'h00);
    check("div1 slave_word", 32'(cap_word[1]), 32'hFF);
    check("div1 sclk_rises", 32'(cap_rises[1]), 32'd8);
    check("div1 slave_count", 32'(cap_cnt[1] - c0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
